// File: rtl/pixel_scanout.sv
// pixel_scanout: plot/clear-written 3-bit framebuffer scanned out as 4x-scaled VGA (clk/reset; x,y,colour,plot,clear,bg_colour in; busy,frame_start,VGA_* out)
module pixel_scanout #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clear,
  input  logic [2:0] bg_colour,
  output logic       busy,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);
  localparam int N = FB_W * FB_H;
  localparam int AW = $clog2(N);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [AW-1:0] FBW = AW'(FB_W);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_V = HW'(H_VIS);
  localparam logic [HW-1:0] H_S0 = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_S1 = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_V = VW'(V_VIS);
  localparam logic [VW-1:0] V_S0 = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_S1 = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [7:0] XL = 8'(FB_W);
  localparam logic [7:0] YL = 8'(FB_H);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic pix_en, we, hs1, vs1, vis1;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [AW-1:0] ra, ca, wa;
  logic [2:0] fill, wd, rgb;
  logic [2:0] mem [N];
  always_comb begin
    we = busy || (plot && x < XL && y < YL);
    wa = busy ? ca : AW'(y) * FBW + AW'(x);
    wd = busy ? fill : colour;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pix_en <= 1'b0;
      VGA_CLK <= 1'b0;
      frame_start <= 1'b0;
      h <= '0;
      v <= '0;
      ra <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      vis1 <= 1'b0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      rgb <= '0;
    end else begin
      pix_en <= !pix_en;
      VGA_CLK <= pix_en;
      frame_start <= pix_en && h == H_LAST && v == V_LAST;
      if (pix_en) begin
        h <= h == H_LAST ? '0 : h + 1'b1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
      end
      ra <= h < H_V && v < V_V ? AW'(v >> 2) * FBW + AW'(h >> 2) : '0;
      hs1 <= !(h >= H_S0 && h < H_S1);
      vs1 <= !(v >= V_S0 && v < V_S1);
      vis1 <= h < H_V && v < V_V;
      VGA_HS <= hs1;
      VGA_VS <= vs1;
      VGA_BLANK_N <= vis1;
      rgb <= vis1 ? mem[ra] : '0;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      ca <= '0;
      fill <= '0;
    end else if (state == IDLE) begin
      if (clear) begin
        state <= CLEAR;
        busy <= 1'b1;
        ca <= '0;
        fill <= bg_colour;
      end
    end else begin
      if (ca == A_LAST) begin
        state <= IDLE;
        busy <= 1'b0;
      end
      ca <= ca + 1'b1;
    end
  assign VGA_SYNC_N = 1'b0;
  assign VGA_R = {10{rgb[2]}};
  assign VGA_G = {10{rgb[1]}};
  assign VGA_B = {10{rgb[0]}};
endmodule

// File: tb/tb_pixel_scanout.sv
// tb_pixel_scanout: randomized self-checking bench for pixel_scanout on a scaled-down raster
module tb_pixel_scanout;
  localparam int FW = 16;
  localparam int FH = 12;
  localparam int N = FW * FH;
  localparam int HT = 80;
  localparam int VT = 55;
  localparam int FRAME = 2 * HT * VT;
  localparam int VISCLK = 2 * (FW * 4) * (FH * 4);
  logic clk = 1'b0;
  logic reset;
  logic [7:0] x, y;
  logic [2:0] colour, bg_colour;
  logic plot, clear;
  logic busy, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  int checks = 0, errors = 0;
  int ccnt[8];
  pixel_scanout #(
    .FB_W(FW), .FB_H(FH),
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear(clear), .bg_colour(bg_colour), .busy(busy), .frame_start(frame_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );
  always #5 clk = ~clk;
  logic [2:0] fb [N];
  bit fbv [N];
  int cyc, js;
  bit clearing;
  logic [2:0] fill;
  logic e_hs, e_vs, e_bl, e_fs, e_vclk, e_busy, e_rgb_ok;
  logic [2:0] e_rgb;
  // Timeline model: k counts clk edges since reset release; raster tick t = floor(k/2)
  // is shown 2 edges later, a clear entered at edge js writes address i at edge js+1+i.
  always @(posedge clk or posedge reset) begin : model
    int k, t, hh, vv, a, i;
    bit vis;
    if (reset) begin
      cyc <= 0;
      clearing <= 0;
      e_hs <= 1; e_vs <= 1; e_bl <= 0; e_rgb <= 0; e_rgb_ok <= 1;
      e_fs <= 0; e_vclk <= 0; e_busy <= 0;
    end else begin
      k = cyc + 1;
      t = (k - 2) / 2;
      hh = t % HT;
      vv = (t / HT) % VT;
      vis = k >= 2 && hh < 64 && vv < 48;
      a = vis ? (vv / 4) * FW + hh / 4 : 0;
      e_hs <= !(k >= 2 && hh >= 68 && hh < 76);
      e_vs <= !(k >= 2 && vv >= 50 && vv < 52);
      e_bl <= vis;
      e_rgb <= vis ? fb[a] : 3'b000;
      e_rgb_ok <= !vis || fbv[a];
      e_fs <= (k % FRAME) == 0;
      e_vclk <= k >= 2 && (k % 2) == 0;
      cyc <= k;
      i = k - js - 1;
      if (clearing) begin
        fb[i] <= fill;
        fbv[i] <= 1;
        if (i == N - 1) clearing <= 0;
        e_busy <= i != N - 1;
      end else begin
        if (plot && x < FW && y < FH) begin
          fb[y * FW + x] <= colour;
          fbv[y * FW + x] <= 1;
        end
        if (clear) begin
          clearing <= 1;
          js <= k;
          fill <= bg_colour;
        end
        e_busy <= clear;
      end
    end
  end
  task automatic do_clear(input logic [2:0] c);
    @(negedge clk);
    bg_colour = c;
    clear = 1;
    @(negedge clk);
    clear = 0;
    for (int n = 0; n < 1000 && busy; n++) @(negedge clk);
  endtask
  task automatic test_frame_scan(input string tag);
    int bad = 0, hs_lo = 0, vs_lo = 0, vis = 0, fs = 0;
    logic [29:0] want;
    foreach (ccnt[i]) ccnt[i] = 0;
    repeat (FRAME) begin
      @(negedge clk);
      checks++;
      if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK, busy, VGA_SYNC_N} !==
          {e_hs, e_vs, e_bl, e_fs, e_vclk, e_busy, 1'b0}) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL %s ctl cyc %0d got %b want %b", tag, cyc,
          {VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK, busy, VGA_SYNC_N},
          {e_hs, e_vs, e_bl, e_fs, e_vclk, e_busy, 1'b0});
      end
      if (e_rgb_ok) begin
        want = {{10{e_rgb[2]}}, {10{e_rgb[1]}}, {10{e_rgb[0]}}};
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== want) begin
          errors++;
          bad++;
          if (bad <= 5) $display("FAIL %s rgb cyc %0d got %h want %h", tag, cyc, {VGA_R, VGA_G, VGA_B}, want);
        end
      end
      if (!VGA_HS) hs_lo++;
      if (!VGA_VS) vs_lo++;
      if (frame_start) fs++;
      if (VGA_BLANK_N) begin
        vis++;
        ccnt[{VGA_R[0], VGA_G[0], VGA_B[0]}]++;
      end
    end
    checks++;
    if (hs_lo != VT * 16) begin errors++; $display("FAIL %s hs_low got %0d want %0d", tag, hs_lo, VT * 16); end
    checks++;
    if (vs_lo != 2 * 2 * HT) begin errors++; $display("FAIL %s vs_low got %0d want %0d", tag, vs_lo, 4 * HT); end
    checks++;
    if (vis != VISCLK) begin errors++; $display("FAIL %s blank_n got %0d want %0d", tag, vis, VISCLK); end
    checks++;
    if (fs != 1) begin errors++; $display("FAIL %s frame_start got %0d want 1", tag, fs); end
  endtask
  task automatic test_reset;
    plot = 0; clear = 0; x = 0; y = 0; colour = 0; bg_colour = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, busy, frame_start, VGA_CLK, VGA_SYNC_N} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 1100000", {VGA_HS, VGA_VS, VGA_BLANK_N, busy, frame_start, VGA_CLK, VGA_SYNC_N});
    end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 30'd0) begin errors++; $display("FAIL reset_rgb got %h want 0", {VGA_R, VGA_G, VGA_B}); end
    reset = 0;
    @(negedge clk);
    checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK} !== 4'b1100) begin
      errors++;
      $display("FAIL edge1 got %b want 1100", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK});
    end
    @(negedge clk);
    checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK} !== 4'b1111) begin
      errors++;
      $display("FAIL edge2 got %b want 1111", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK});
    end
  endtask
  task automatic test_clear;
    int n = 0;
    @(negedge clk);
    bg_colour = 3'b010;
    clear = 1;
    @(negedge clk);
    clear = 0;
    while (busy && n < 1000) begin
      n++;
      plot = n == 50;
      x = 0; y = 0; colour = 3'b111;
      @(negedge clk);
    end
    plot = 0;
    checks++;
    if (n != N) begin errors++; $display("FAIL busy_len got %0d want %0d", n, N); end
    test_frame_scan("clear");
    checks++;
    if (ccnt[2] != VISCLK) begin errors++; $display("FAIL clear_green got %0d want %0d", ccnt[2], VISCLK); end
  endtask
  task automatic test_plot;
    logic [18:0] tbl [7];
    logic [18:0] e;
    tbl = '{{8'd10, 8'd5, 3'b100}, {8'd16, 8'd3, 3'b111}, {8'd2, 8'd12, 3'b111},
            {8'd255, 8'd0, 3'b111}, {8'd0, 8'd255, 3'b111}, {8'd160, 8'd3, 3'b111}, {8'd2, 8'd120, 3'b111}};
    do_clear(3'b000);
    foreach (tbl[i]) begin
      e = tbl[i];
      {x, y, colour} = e;
      plot = 1;
      @(negedge clk);
    end
    plot = 0;
    test_frame_scan("plot");
    checks++;
    if (ccnt[4] != 32) begin errors++; $display("FAIL plot_red got %0d want 32", ccnt[4]); end
    checks++;
    if (ccnt[0] != VISCLK - 32) begin errors++; $display("FAIL plot_bg got %0d want %0d", ccnt[0], VISCLK - 32); end
    checks++;
    if (ccnt[7] != 0) begin errors++; $display("FAIL plot_oob got %0d want 0", ccnt[7]); end
  endtask
  task automatic test_back_to_back;
    fork
      test_frame_scan("b2b");
      begin
        for (int n = 0; n < 3000; n++) begin
          x = 8'($urandom_range(0, 19));
          y = 8'($urandom_range(0, 15));
          colour = 3'($urandom);
          plot = $urandom_range(0, 3) != 0;
          @(negedge clk);
        end
        plot = 0;
      end
    join
  endtask
  task automatic test_clear_plot_same;
    @(negedge clk);
    bg_colour = 3'b101;
    clear = 1;
    x = 3; y = 3; colour = 3'b011;
    plot = 1;
    @(negedge clk);
    clear = 0;
    plot = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", busy); end
    for (int n = 0; n < 1000 && busy; n++) @(negedge clk);
    test_frame_scan("same");
    checks++;
    if (ccnt[5] != VISCLK) begin errors++; $display("FAIL same_fill got %0d want %0d", ccnt[5], VISCLK); end
  endtask
  task automatic test_reset_mid_clear;
    @(negedge clk);
    bg_colour = 3'b110;
    clear = 1;
    @(negedge clk);
    clear = 0;
    repeat (100) @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 0;
    test_frame_scan("abort");
    checks++;
    if (ccnt[6] != 100 * 32) begin errors++; $display("FAIL abort_new got %0d want %0d", ccnt[6], 3200); end
    checks++;
    if (ccnt[5] != (N - 100) * 32) begin errors++; $display("FAIL abort_old got %0d want %0d", ccnt[5], (N - 100) * 32); end
  endtask
  initial begin
    test_reset;
    test_clear;
    test_plot;
    test_back_to_back;
    test_clear_plot_same;
    test_reset_mid_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
